usb32_polling_ltssm: RTL and testbench

- Parametrised Polling-substate controller for the USB3.2 link LTSSM: drives the substate sequence LFPS -> LFPSPLUS (Gen2 only) -> RXEQ -> ACTIVE -> CONFIGURATION -> IDLE over NUM_LANES lanes.
- Sits between the top-level LTSSM (RX_DETECT/U0/SS_DISABLE/COMPLIANCE decisions) and the per-lane LFPS/TS PHY agents.
- Reports the current substate using the team's lane_ltssm_substate_type_enum ordinals.

---
 rtl/usb32_polling_ltssm.sv | 393 +++++++++++++++++++++++++++++++++++++++
 tb/tb_usb32_polling_ltssm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/usb32_polling_ltssm.sv
// usb32_polling_ltssm
// Polling-substate controller for the USB3.2 link LTSSM. Walks the link through
// LFPS -> LFPSPLUS (Gen2 only) -> RXEQ -> ACTIVE -> CONFIGURATION -> POLLING_IDLE
// and reports success (done_u0) or the failure target (SS_DISABLE / COMPLIANCE).
// Optional feature macro: USB32_LANE_DEGRADE_EN -- on the first ACTIVE timeout
// where lane 0 is healthy, the lagging lanes are dropped instead of failing.
module usb32_polling_ltssm #(
   parameter int NUM_LANES      = 2,
   parameter int LFPS_TX_MIN    = 16,
   parameter int LFPS_RX_MIN    = 2,
   parameter int RXEQ_TX_CNT    = 64,
   parameter int TS1_RX_REQ     = 8,
   parameter int TS2_RX_REQ     = 8,
   parameter int TS2_TX_REQ     = 16,
   parameter int IDLE_REQ       = 8,
   parameter int TIMEOUT_CYCLES = 360
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 polling_start,
   input  logic                 polling_abort,
   input  logic [NUM_LANES-1:0] lane_en,
   input  logic                 speed_cap_gen2,
   input  logic [NUM_LANES-1:0] lfps_rx_burst,
   input  logic [NUM_LANES-1:0] lfps_rx_scd,
   input  logic                 lfps_tx_done,
   input  logic                 ts_tx_sent,
   input  logic [NUM_LANES-1:0] ts1_rx_valid,
   input  logic [NUM_LANES-1:0] ts2_rx_valid,
   input  logic [NUM_LANES-1:0] idle_rx,
   output logic                 lfps_tx_req,
   output logic [1:0]           tx_pattern,
   output logic [3:0]           substate,
   output logic [NUM_LANES-1:0] lane_active,
   output logic                 negotiated_gen2,
   output logic                 lane_degraded,
   output logic                 done_u0,
   output logic                 fail_disable,
   output logic                 fail_compliance
);

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int TX_MAX = max_of(max_of(LFPS_TX_MIN, RXEQ_TX_CNT), max_of(TS2_TX_REQ, IDLE_REQ));
   localparam int RX_MAX = max_of(max_of(LFPS_RX_MIN, TS1_RX_REQ), max_of(TS2_RX_REQ, IDLE_REQ));
   localparam int TXW    = $clog2(TX_MAX + 1);
   localparam int RXW    = $clog2(RX_MAX + 1);
   localparam int TMW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [TXW-1:0] TX_SAT     = {TXW{1'b1}};
   localparam logic [RXW-1:0] RX_SAT     = {RXW{1'b1}};
   localparam logic [TMW-1:0] TIMER_LAST = TMW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LFPS,
      S_LFPSPLUS,
      S_RXEQ,
      S_ACTIVE,
      S_CONFIG,
      S_PIDLE
   } state_t;

   // lane_ltssm_substate_type_enum ordinal of each internal state
   function automatic logic [3:0] substate_code(input state_t s);
      logic [3:0] code;
      case (s)
         S_LFPS:     code = 4'd7;
         S_LFPSPLUS: code = 4'd8;
         S_RXEQ:     code = 4'd11;
         S_ACTIVE:   code = 4'd12;
         S_CONFIG:   code = 4'd13;
         S_PIDLE:    code = 4'd14;
         default:    code = 4'd0;
      endcase
      return code;
   endfunction

   // transmit pattern requested from the PHY agents in each state
   function automatic logic [1:0] pattern_code(input state_t s);
      logic [1:0] code;
      case (s)
         S_RXEQ, S_ACTIVE: code = 2'd1;
         S_CONFIG:         code = 2'd2;
         S_PIDLE:          code = 2'd3;
         default:          code = 2'd0;
      endcase
      return code;
   endfunction

   state_t state;
   state_t state_nxt;

   logic [TXW-1:0]       tx_cnt;
   logic [TXW-1:0]       tx_inc;
   logic [TXW-1:0]       tx_req;
   logic                 tx_ev;
   logic [RXW-1:0]       rx_cnt [NUM_LANES];
   logic [RXW-1:0]       rx_inc [NUM_LANES];
   logic [RXW-1:0]       rx_req;
   logic [NUM_LANES-1:0] rx_ev;
   logic [NUM_LANES-1:0] lane_ok;
   logic [TMW-1:0]       timer;

   logic tx_met;
   logic lanes_met;
   logic timeout;
   logic scd_now;
   logic scd_seen;
   logic burst_seen;
   logic entering;
   logic start_accept;
   logic gen2_set;
   logic done_nxt;
   logic fdis_nxt;
   logic fcomp_nxt;

`ifdef USB32_LANE_DEGRADE_EN
   logic degrade_used;
   logic degrade_fire;
`endif

   // Per-state event selection, saturating counter increments and exit checks.
   always_comb begin
      tx_ev  = 1'b0;
      rx_ev  = {NUM_LANES{1'b0}};
      tx_req = {TXW{1'b0}};
      rx_req = {RXW{1'b0}};
      case (state)
         S_LFPS: begin
            tx_ev  = lfps_tx_done;
            rx_ev  = lfps_rx_burst;
            tx_req = TXW'(LFPS_TX_MIN);
            rx_req = RXW'(LFPS_RX_MIN);
         end
         S_LFPSPLUS: begin
            tx_ev  = lfps_tx_done;
            tx_req = TXW'(LFPS_TX_MIN);
         end
         S_RXEQ: begin
            tx_ev  = ts_tx_sent;
            tx_req = TXW'(RXEQ_TX_CNT);
         end
         S_ACTIVE: begin
            rx_ev  = ts1_rx_valid;
            rx_req = RXW'(TS1_RX_REQ);
         end
         S_CONFIG: begin
            tx_ev  = ts_tx_sent;
            rx_ev  = ts2_rx_valid;
            tx_req = TXW'(TS2_TX_REQ);
            rx_req = RXW'(TS2_RX_REQ);
         end
         S_PIDLE: begin
            tx_ev  = ts_tx_sent;
            rx_ev  = idle_rx;
            tx_req = TXW'(IDLE_REQ);
            rx_req = RXW'(IDLE_REQ);
         end
         default: begin
            tx_ev = 1'b0;
         end
      endcase
      // inactive lanes never contribute
      rx_ev   = rx_ev & lane_active;
      scd_now = |(lfps_rx_scd & lane_active);
      tx_inc  = (tx_ev && (tx_cnt != TX_SAT)) ? tx_cnt + TXW'(1) : tx_cnt;
      for (int i = 0; i < NUM_LANES; i++) begin
         rx_inc[i]  = (rx_ev[i] && (rx_cnt[i] != RX_SAT)) ? rx_cnt[i] + RXW'(1) : rx_cnt[i];
         lane_ok[i] = !lane_active[i] || (rx_inc[i] >= rx_req);
      end
      // exit checks include this cycle's events so a last-cycle exit beats the timeout
      tx_met    = (tx_inc >= tx_req);
      lanes_met = &lane_ok;
      timeout   = (timer == TIMER_LAST) && (state != S_IDLE) && (state != S_RXEQ);
   end

   // Next-state decision and one-cycle result pulses; abort outranks everything.
   always_comb begin
      state_nxt = state;
      gen2_set  = 1'b0;
      done_nxt  = 1'b0;
      fdis_nxt  = 1'b0;
      fcomp_nxt = 1'b0;
`ifdef USB32_LANE_DEGRADE_EN
      degrade_fire = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (polling_start) begin
               state_nxt = S_LFPS;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_LFPS: begin
            if (tx_met && lanes_met) begin
               if (speed_cap_gen2 && (scd_seen || scd_now)) begin
                  state_nxt = S_LFPSPLUS;
                  gen2_set  = 1'b1;
               end else begin
                  state_nxt = S_RXEQ;
               end
            end else if (timeout) begin
               state_nxt = S_IDLE;
               // a partner that never sent LFPS is treated as a compliance load
               if (burst_seen || (|rx_ev)) begin
                  fdis_nxt = 1'b1;
               end else begin
                  fcomp_nxt = 1'b1;
               end
            end else begin
               state_nxt = S_LFPS;
            end
         end
         S_LFPSPLUS: begin
            if (tx_met) begin
               state_nxt = S_RXEQ;
            end else if (timeout) begin
               state_nxt = S_IDLE;
               fdis_nxt  = 1'b1;
            end else begin
               state_nxt = S_LFPSPLUS;
            end
         end
         S_RXEQ: begin
            if (tx_met) begin
               state_nxt = S_ACTIVE;
            end else begin
               state_nxt = S_RXEQ;
            end
         end
         S_ACTIVE: begin
            if (lanes_met) begin
               state_nxt = S_CONFIG;
            end else if (timeout) begin
`ifdef USB32_LANE_DEGRADE_EN
               if (!degrade_used && lane_ok[0]) begin
                  state_nxt    = S_CONFIG;
                  degrade_fire = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
                  fdis_nxt  = 1'b1;
               end
`else
               state_nxt = S_IDLE;
               fdis_nxt  = 1'b1;
`endif
            end else begin
               state_nxt = S_ACTIVE;
            end
         end
         S_CONFIG: begin
            if (tx_met && lanes_met) begin
               state_nxt = S_PIDLE;
            end else if (timeout) begin
               state_nxt = S_IDLE;
               fdis_nxt  = 1'b1;
            end else begin
               state_nxt = S_CONFIG;
            end
         end
         S_PIDLE: begin
            if (tx_met && lanes_met) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end else if (timeout) begin
               state_nxt = S_IDLE;
               fdis_nxt  = 1'b1;
            end else begin
               state_nxt = S_PIDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (polling_abort) begin
         state_nxt = S_IDLE;
         gen2_set  = 1'b0;
         done_nxt  = 1'b0;
         fdis_nxt  = 1'b0;
         fcomp_nxt = 1'b0;
`ifdef USB32_LANE_DEGRADE_EN
         degrade_fire = 1'b0;
`endif
      end else begin
         gen2_set = gen2_set;
      end
      entering     = (state_nxt != state);
      start_accept = (state == S_IDLE) && (state_nxt == S_LFPS);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Counters, timer, lane mask and per-entry flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_cnt          <= {TXW{1'b0}};
         timer           <= {TMW{1'b0}};
         lane_active     <= {NUM_LANES{1'b0}};
         negotiated_gen2 <= 1'b0;
         scd_seen        <= 1'b0;
         burst_seen      <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            rx_cnt[i] <= {RXW{1'b0}};
         end
      end else begin
         if (entering) begin
            tx_cnt <= {TXW{1'b0}};
            timer  <= {TMW{1'b0}};
            for (int i = 0; i < NUM_LANES; i++) begin
               rx_cnt[i] <= {RXW{1'b0}};
            end
         end else begin
            tx_cnt <= tx_inc;
            for (int i = 0; i < NUM_LANES; i++) begin
               rx_cnt[i] <= rx_inc[i];
            end
            if (timer != TIMER_LAST) begin
               timer <= timer + TMW'(1);
            end
         end
         if (start_accept) begin
            // an empty mask still trains lane 0
            lane_active     <= (lane_en == {NUM_LANES{1'b0}}) ? NUM_LANES'(1) : lane_en;
            negotiated_gen2 <= 1'b0;
            scd_seen        <= 1'b0;
            burst_seen      <= 1'b0;
         end else begin
            if (gen2_set) begin
               negotiated_gen2 <= 1'b1;
            end
            if (state == S_LFPS) begin
               scd_seen   <= scd_seen | scd_now;
               burst_seen <= burst_seen | (|rx_ev);
            end
`ifdef USB32_LANE_DEGRADE_EN
            if (degrade_fire) begin
               lane_active <= lane_active & lane_ok;
            end
`endif
         end
      end
   end

`ifdef USB32_LANE_DEGRADE_EN
   // Degrade bookkeeping: one lane drop allowed per Polling entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_degraded <= 1'b0;
         degrade_used  <= 1'b0;
      end else if (start_accept) begin
         lane_degraded <= 1'b0;
         degrade_used  <= 1'b0;
      end else if (degrade_fire) begin
         lane_degraded <= 1'b1;
         degrade_used  <= 1'b1;
      end
   end
`else
   assign lane_degraded = 1'b0;
`endif

   // Registered outputs decoded from the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         substate        <= 4'd0;
         tx_pattern      <= 2'd0;
         lfps_tx_req     <= 1'b0;
         done_u0         <= 1'b0;
         fail_disable    <= 1'b0;
         fail_compliance <= 1'b0;
      end else begin
         substate        <= substate_code(state_nxt);
         tx_pattern      <= pattern_code(state_nxt);
         lfps_tx_req     <= (state_nxt == S_LFPS) || (state_nxt == S_LFPSPLUS);
         done_u0         <= done_nxt;
         fail_disable    <= fdis_nxt;
         fail_compliance <= fcomp_nxt;
      end
   end

endmodule

// File: tb/tb_usb32_polling_ltssm.sv
// Directed, table-driven bench for usb32_polling_ltssm (default parameters).
// Each record holds inputs steady for n clock edges, then the outputs are
// compared on the following falling edge.
module tb_usb32_polling_ltssm;

   logic       clk = 1'b0;
   logic       reset, polling_start, polling_abort, speed_cap_gen2;
   logic [1:0] lane_en, lfps_rx_burst, lfps_rx_scd, ts1_rx_valid, ts2_rx_valid, idle_rx;
   logic       lfps_tx_done, ts_tx_sent;
   logic       lfps_tx_req, negotiated_gen2, lane_degraded, done_u0, fail_disable, fail_compliance;
   logic [1:0] tx_pattern, lane_active;
   logic [3:0] substate;

   always #5 clk = ~clk;

   usb32_polling_ltssm dut (
      .clk(clk), .reset(reset), .polling_start(polling_start), .polling_abort(polling_abort),
      .lane_en(lane_en), .speed_cap_gen2(speed_cap_gen2), .lfps_rx_burst(lfps_rx_burst),
      .lfps_rx_scd(lfps_rx_scd), .lfps_tx_done(lfps_tx_done), .ts_tx_sent(ts_tx_sent),
      .ts1_rx_valid(ts1_rx_valid), .ts2_rx_valid(ts2_rx_valid), .idle_rx(idle_rx),
      .lfps_tx_req(lfps_tx_req), .tx_pattern(tx_pattern), .substate(substate),
      .lane_active(lane_active), .negotiated_gen2(negotiated_gen2), .lane_degraded(lane_degraded),
      .done_u0(done_u0), .fail_disable(fail_disable), .fail_compliance(fail_compliance)
   );

   typedef struct {
      int         n;
      logic       rst, st, ab, cap;
      logic [1:0] len;
      logic       ltx;
      logic [1:0] lrx, scd;
      logic       ttx;
      logic [1:0] t1, t2, idl;
      logic [3:0] sub;
      logic       done, fdis, fcomp, full;
      logic [1:0] la;
      logic       g2, deg;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(input int n, input logic rst, input logic st, input logic ab,
                               input logic cap, input logic [1:0] len, input logic ltx,
                               input logic [1:0] lrx, input logic [1:0] scd, input logic ttx,
                               input logic [1:0] t1, input logic [1:0] t2, input logic [1:0] idl,
                               input logic [3:0] sub, input logic done, input logic fdis,
                               input logic fcomp, input logic full, input logic [1:0] la,
                               input logic g2, input logic deg);
      vec_t v;
      v.n = n; v.rst = rst; v.st = st; v.ab = ab; v.cap = cap; v.len = len; v.ltx = ltx;
      v.lrx = lrx; v.scd = scd; v.ttx = ttx; v.t1 = t1; v.t2 = t2; v.idl = idl;
      v.sub = sub; v.done = done; v.fdis = fdis; v.fcomp = fcomp; v.full = full;
      v.la = la; v.g2 = g2; v.deg = deg;
      tbl.push_back(v);
   endfunction

   // expected transmit pattern / LFPS request for a substate ordinal
   function automatic logic [1:0] pat_of(input logic [3:0] s);
      if (s == 4'd11 || s == 4'd12) return 2'd1;
      if (s == 4'd13) return 2'd2;
      if (s == 4'd14) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic req_of(input logic [3:0] s);
      return (s == 4'd7 || s == 4'd8);
   endfunction

   task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; polling_start = v.st; polling_abort = v.ab; speed_cap_gen2 = v.cap;
      lane_en = v.len; lfps_tx_done = v.ltx; lfps_rx_burst = v.lrx; lfps_rx_scd = v.scd;
      ts_tx_sent = v.ttx; ts1_rx_valid = v.t1; ts2_rx_valid = v.t2; idle_rx = v.idl;
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t z;
      z = '{n: 1, default: '0};
      z.rst = 1'b1;
      drive(z);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_substate", -1, substate, 4'd0);
      chk("rst_pattern", -1, tx_pattern, 2'd0);
      chk("rst_lfps_req", -1, lfps_tx_req, 1'b0);
      chk("rst_lane_active", -1, lane_active, 2'b00);
      chk("rst_pulses", -1, {done_u0, fail_disable, fail_compliance}, 3'b000);
      chk("rst_gen2_deg", -1, {negotiated_gen2, lane_degraded}, 2'b00);

      // start together with abort must not leave IDLE
      z.rst = 1'b0; z.st = 1'b1; z.ab = 1'b1; z.len = 2'b11;
      drive(z);
      @(posedge clk);
      @(negedge clk);
      chk("start_abort_sub", -1, substate, 4'd0);
      chk("start_abort_la", -1, lane_active, 2'b00);

      //   n  rst st ab cap len   ltx lrx   scd   ttx t1    t2    idl    sub  dn fd fc full la   g2 dg
      // Gen1 x2 nominal
      add(1,   0, 1, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(15,  0, 0, 0, 0, 2'b00, 1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b11, 0, 0);
      add(400, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b11, 0, 0);
      add(63,  0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 12, 0, 0, 0, 1, 2'b11, 0, 0);
      add(7,   0, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 12, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(7,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(8,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 14, 0, 0, 0, 1, 2'b11, 0, 0);
      add(7,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b11, 14, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b11, 0,  1, 0, 0, 0, 2'b00, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // Gen2: SCD on lane 0, LFPSPLUS sends 16 more bursts
      add(1,   0, 1, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b01, 0, 0);
      add(1,   0, 0, 0, 1, 2'b00, 1, 2'b01, 2'b01, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b01, 0, 0);
      add(15,  0, 0, 0, 1, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8,  0, 0, 0, 1, 2'b01, 1, 0);
      add(15,  0, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8,  0, 0, 0, 1, 2'b01, 1, 0);
      add(1,   0, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b01, 1, 0);
      add(1,   0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // SCD only on an inactive lane: stays Gen1
      add(1,   0, 1, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b01, 0, 0);
      add(16,  0, 0, 0, 1, 2'b00, 1, 2'b01, 2'b10, 0, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b01, 0, 0);
      add(1,   0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // empty lane mask trains lane 0
      add(1,   0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b01, 0, 0);
      add(1,   0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // silent partner -> compliance at cycle 360
      add(1,   0, 1, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(359, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 0, 2'b00, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 1, 0, 2'b00, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // LFPS timeout with bursts seen -> disable
      add(1,   0, 1, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(360, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 1, 0, 0, 2'b00, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // lane 1 TS1 missing in ACTIVE
      add(1,   0, 1, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(16,  0, 0, 0, 0, 2'b00, 1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b11, 0, 0);
      add(64,  0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 12, 0, 0, 0, 1, 2'b11, 0, 0);
      add(359, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 12, 0, 0, 0, 1, 2'b11, 0, 0);
`ifdef USB32_LANE_DEGRADE_EN
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 13, 0, 0, 0, 1, 2'b01, 0, 1);
      add(16,  0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b00, 14, 0, 0, 0, 1, 2'b01, 0, 1);
      add(8,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01, 0,  1, 0, 0, 0, 2'b00, 0, 0);
`else
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0,  0, 1, 0, 0, 2'b00, 0, 0);
`endif
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // exit on the final lane-1 TS2 at cycle 359 beats the timeout
      add(1,   0, 1, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(16,  0, 0, 0, 0, 2'b00, 1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b11, 0, 0);
      add(64,  0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 12, 0, 0, 0, 1, 2'b11, 0, 0);
      add(8,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(7,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(352, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b10, 2'b00, 14, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 14, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // abort together with the CONFIGURATION exit
      add(1,   0, 1, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(16,  0, 0, 0, 0, 2'b00, 1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 11, 0, 0, 0, 1, 2'b11, 0, 0);
      add(64,  0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 12, 0, 0, 0, 1, 2'b11, 0, 0);
      add(8,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(15,  0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 2'b00, 13, 0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0);
      // reset mid-operation
      add(1,   0, 1, 0, 1, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(5,   0, 0, 0, 1, 2'b00, 1, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 7,  0, 0, 0, 1, 2'b11, 0, 0);
      add(1,   1, 0, 0, 0, 2'b00, 1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 1, 2'b00, 0, 0);
      add(1,   0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 1, 2'b00, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         repeat (tbl[i].n) @(posedge clk);
         @(negedge clk);
         chk("substate", i, substate, tbl[i].sub);
         chk("tx_pattern", i, tx_pattern, pat_of(tbl[i].sub));
         chk("lfps_tx_req", i, lfps_tx_req, req_of(tbl[i].sub));
         chk("done_u0", i, done_u0, tbl[i].done);
         chk("fail_disable", i, fail_disable, tbl[i].fdis);
         chk("fail_compliance", i, fail_compliance, tbl[i].fcomp);
         if (tbl[i].full) begin
            chk("lane_active", i, lane_active, tbl[i].la);
            chk("negotiated_gen2", i, negotiated_gen2, tbl[i].g2);
            chk("lane_degraded", i, lane_degraded, tbl[i].deg);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
